// File: rtl/simple_transmitter.sv
// UART transmitter: pops words from an FWFT FIFO and sends start bit, data LSB first,
// then STOP_BITS stop bits. Line idles high; dout comes straight from a register.
//
// state           | meaning
// STATE_WAIT      | idle, line high, waiting for a word in the FIFO
// STATE_READ_WORD | one-cycle pop; frame loaded into the shift register
// STATE_SEND_BITS | shifting the frame out, CLOCKS_PER_BIT cycles per bit
module simple_transmitter #(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter logic [31:0] WORD_WIDTH      = 32'd8,
  parameter logic [31:0] STOP_BITS       = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  empty,
  output logic                  re,
  output logic                  dout,
  output logic                  busy
);

  localparam logic [31:0] CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam logic [31:0] LAST_CLK       = CLOCKS_PER_BIT - 32'd1;
  localparam int          FRAME_BITS     = int'(WORD_WIDTH + 32'd1 + STOP_BITS);
  localparam int          BIT_CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    STATE_WAIT,
    STATE_READ_WORD,
    STATE_SEND_BITS
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [31:0]            r_clk_cnt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [FRAME_BITS-1:0]  r_shift;
  logic                   w_bit_end;
  logic                   w_frame_end;

  assign w_bit_end   = (r_clk_cnt == LAST_CLK);
  assign w_frame_end = w_bit_end && (r_bit_cnt == LAST_BIT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STATE_WAIT:      if (!empty) w_state_next = STATE_READ_WORD;
      STATE_READ_WORD: w_state_next = STATE_SEND_BITS;
      STATE_SEND_BITS: if (w_frame_end) w_state_next = STATE_WAIT;
      default:         w_state_next = STATE_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= STATE_WAIT;
    else     r_state <= w_state_next;
  end

  // Shifting in ones leaves the register all ones once the last stop bit is out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '1;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        STATE_READ_WORD: begin
          r_shift   <= {{STOP_BITS{1'b1}}, din, 1'b0};
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
        end
        STATE_SEND_BITS: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
            r_bit_cnt <= w_frame_end ? '0 : r_bit_cnt + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 32'd1;
          end
        end
        default: begin
          r_shift   <= '1;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign dout = r_shift[0];
  assign re   = (r_state == STATE_READ_WORD);
  assign busy = (r_state != STATE_WAIT);

endmodule

// File: tb/tb_simple_transmitter.sv
// Bench for simple_transmitter: FIFO models feed two instances (1 and 2 stop bits);
// a line decoder pops expected words from a scoreboard queue for the 1-stop instance.
module tb_simple_transmitter;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din1, din2;
  logic       empty1, empty2, re1, re2, dout1, dout2, busy1, busy2;

  logic [7:0] mem1 [0:1023];
  logic [7:0] mem2 [0:1023];
  logic [9:0] wp1 = '0, rp1 = '0, wp2 = '0, rp2 = '0;

  assign empty1 = (wp1 == rp1);
  assign empty2 = (wp2 == rp2);
  assign din1   = mem1[rp1];
  assign din2   = mem2[rp2];

  always @(posedge clk) begin
    if (re1) rp1 <= rp1 + 10'd1;
    if (re2) rp2 <= rp2 + 10'd1;
  end

  simple_transmitter #(
    .CLOCK_FREQUENCY(32'd1_600_000), .BAUD_RATE(32'd100_000),
    .WORD_WIDTH(32'd8), .STOP_BITS(32'd1)
  ) dut1 (
    .clk(clk), .rst(rst), .din(din1), .empty(empty1),
    .re(re1), .dout(dout1), .busy(busy1)
  );

  simple_transmitter #(
    .CLOCK_FREQUENCY(32'd1_600_000), .BAUD_RATE(32'd100_000),
    .WORD_WIDTH(32'd8), .STOP_BITS(32'd2)
  ) dut2 (
    .clk(clk), .rst(rst), .din(din2), .empty(empty2),
    .re(re2), .dout(dout2), .busy(busy2)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_decoded = 0;
  int         n_scored  = 0;
  bit         mon_en = 1'b1;
  logic [7:0] exp1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sel2, input logic [7:0] w, input bit scored);
    if (sel2) begin
      mem2[wp2] = w;
      wp2 = wp2 + 10'd1;
    end else begin
      mem1[wp1] = w;
      wp1 = wp1 + 10'd1;
      if (scored) begin
        exp1.push_back(w);
        n_scored++;
      end
    end
  endtask

  // Line decoder / scoreboard monitor for dut1: samples each bit at its centre.
  initial begin
    logic       prev;
    logic       start_b, stop_b;
    logic [7:0] data;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && dout1 === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        start_b = dout1;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          data[k] = dout1;
        end
        repeat (CPB) @(negedge clk);
        stop_b = dout1;
        n_decoded++;
        if (exp1.size() == 0) begin
          chk("sb_extra_frame", 32'(data), 32'hFFFF_FFFF);
        end else begin
          e = exp1.pop_front();
          chk("sb_word", 32'(data), 32'(e));
        end
        chk("sb_start_bit", 32'(start_b), 32'd0);
        chk("sb_stop_bit", 32'(stop_b), 32'd1);
      end
      prev = dout1;
    end
  end

  always @(negedge clk) begin
    if (re1 === 1'b1) chk("re1_while_empty", 32'(empty1), 32'd0);
    if (re2 === 1'b1) chk("re2_while_empty", 32'(empty2), 32'd0);
  end

  // Push one word into an idle DUT and check every cycle of its frame.
  task automatic frame_exact(input string tag, input bit sel2, input logic [7:0] w, input int stops);
    int          bad_dout = 0;
    int          bad_re   = 0;
    int          nbits;
    logic [10:0] fr;
    nbits = 9 + stops;
    fr = {2'b11, w, 1'b0};
    @(negedge clk);
    chk({tag, "_idle_before"}, 32'(sel2 ? busy2 : busy1), 32'd0);
    push(sel2, w, !sel2);
    @(negedge clk);
    chk({tag, "_re_pulse"}, 32'(sel2 ? re2 : re1), 32'd1);
    chk({tag, "_busy_read"}, 32'(sel2 ? busy2 : busy1), 32'd1);
    for (int c = 0; c < CPB * nbits; c++) begin
      @(negedge clk);
      if ((sel2 ? dout2 : dout1) !== fr[c / CPB]) bad_dout++;
      if ((sel2 ? re2 : re1) !== 1'b0) bad_re++;
    end
    chk({tag, "_wave_bad_cycles"}, 32'(bad_dout), 32'd0);
    chk({tag, "_extra_re"}, 32'(bad_re), 32'd0);
    @(negedge clk);
    chk({tag, "_busy_done"}, 32'(sel2 ? busy2 : busy1), 32'd0);
    chk({tag, "_dout_idle"}, 32'(sel2 ? dout2 : dout1), 32'd1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    logic       dv [0:399];
    int         re_t [$];
    int         run, i0, idx;
    bit         seen;
    logic [7:0] w;

    // 1: reset and idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dout1 !== 1'b1 || re1 !== 1'b0 || busy1 !== 1'b0) bad++;
      if (dout2 !== 1'b1 || re2 !== 1'b0 || busy2 !== 1'b0) bad++;
    end
    chk("t1_idle_bad_cycles", 32'(bad), 32'd0);

    // 2: single frame 0x55
    frame_exact("t2_55", 1'b0, 8'h55, 1);

    // 4: two stop bits, 0xFF
    frame_exact("t4_ff_2stop", 1'b1, 8'hFF, 2);

    // 3: back-to-back A3, 0F
    @(negedge clk);
    push(1'b0, 8'hA3, 1'b1);
    push(1'b0, 8'h0F, 1'b1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      dv[i] = dout1;
      if (re1 === 1'b1) re_t.push_back(i);
    end
    chk("t3_re_count", 32'(re_t.size()), 32'd2);
    if (re_t.size() >= 2) begin
      chk("t3_first_re_latency", 32'(re_t[0]), 32'd0);
      chk("t3_re_spacing", 32'(re_t[1] - re_t[0]), 32'd162);
      i0 = re_t[0];
      run = 0;
      idx = i0 + 1 + 9 * CPB;
      while (idx < 400 && dv[idx] === 1'b1) begin
        run++;
        idx++;
      end
      chk("t3_gap_high_cycles", 32'(run), 32'd18);
    end

    // 5: reset in the middle of data bit 3 of 0x00
    mon_en = 1'b0;
    @(negedge clk);
    push(1'b0, 8'h00, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (re1 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_re_seen", 32'(seen), 32'd1);
    repeat (1 + 4 * CPB + CPB / 2) @(negedge clk);
    chk("t5_mid_frame_low", 32'(dout1), 32'd0);
    chk("t5_mid_frame_busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_dout", 32'(dout1), 32'd1);
    chk("t5_rst_busy", 32'(busy1), 32'd0);
    chk("t5_rst_re", 32'(re1), 32'd0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy1 !== 1'b0 || dout1 !== 1'b1 || re1 !== 1'b0) bad++;
    end
    chk("t5_stays_idle", 32'(bad), 32'd0);
    mon_en = 1'b1;
    frame_exact("t5_restart_3c", 1'b0, 8'h3C, 1);

    // 6: 256 random words through the decoder scoreboard
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom_range(0, 255));
      push(1'b0, w, 1'b1);
    end
    for (int i = 0; i < 60000 && exp1.size() != 0; i++) @(negedge clk);
    repeat (200) @(negedge clk);
    chk("t6_scoreboard_drained", 32'(exp1.size()), 32'd0);
    chk("t6_frames_decoded", 32'(n_decoded), 32'(n_scored));
    chk("t6_fifo_emptied", 32'(empty1), 32'd1);
    chk("t6_idle_after", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
